// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_responder_pkg;

   // Responder control states: IDLE accepts requests, BUSY waits out read latency.
   typedef enum logic {
      DMEM_IDLE = 1'b0,
      DMEM_BUSY = 1'b1
   } dmem_state_t;

   // wen value that turns an enabled request into a read.
   localparam logic [3:0] DMEM_WEN_READ = 4'b0000;

   // Latency counter width; READ_LAT is at most 15.
   localparam int DMEM_CNT_BITS = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Data SRAM port between the MEM stage (master) and the responder (slave).
// Latency: n/a (wires only).
// Backpressure: stallreq_mem from the slave holds the master's request.
interface dmem_responder_if;

   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        stallreq_mem;

   modport master (
      output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      input  data_sram_rdata, stallreq_mem
   );

   modport slave (
      input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      output data_sram_rdata, stallreq_mem
   );

endinterface

// File: rtl/dmem_byte_ram.sv
// Word array with per-byte write enables and a registered read port.
// Latency: write commits and read data registers on the same edge as the request.
// Backpressure: none; the caller decides when ports are enabled.
module dmem_byte_ram #(
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic [3:0]           wr_be,
   input  logic [ADDR_BITS-1:0] wr_idx,
   input  logic [31:0]          wr_dat,
   input  logic                 rd_en,
   input  logic [ADDR_BITS-1:0] rd_idx,
   output logic [31:0]          rd_dat
);

   logic [31:0] mem [2**ADDR_BITS];

   // Byte-lane writes and synchronous read; the array itself has no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_be[i]) begin
            mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
         end
      end
      if (rd_en) begin
         rd_dat <= mem[rd_idx];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the data SRAM port: byte-enable writes, reads with READ_LAT cycles of latency.
// Latency: writes commit at acceptance; read data valid READ_LAT cycles after the request cycle.
// Backpressure: stallreq_mem high while a multi-cycle read is outstanding; requests then are ignored.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_BITS = 10,
   parameter int READ_LAT  = 1
) (
   input  logic          clk,
   input  logic          rst,
   dmem_responder_if.slave bus
);

   dmem_state_t               state, state_nxt;
   logic [DMEM_CNT_BITS-1:0]  cnt, cnt_nxt;
   logic [ADDR_BITS-1:0]      req_idx, lat_idx, lat_idx_nxt, rd_idx;
   logic                      accept, wr_acc, rd_acc, rd_en, rd_zero;
   logic [3:0]                wr_be;
   logic [31:0]               ram_q;
   logic                      unused_addr_bits;

   // Word access only: byte offset and bits above the array span are dropped (addresses alias).
   assign req_idx          = bus.data_sram_addr[ADDR_BITS+1:2];
   assign unused_addr_bits = ^{bus.data_sram_addr[31:ADDR_BITS+2], bus.data_sram_addr[1:0]};

   assign bus.stallreq_mem = (state == DMEM_BUSY);
   assign accept           = bus.data_sram_en && (state == DMEM_IDLE) && !rst;
   assign wr_acc           = accept && (bus.data_sram_wen != DMEM_WEN_READ);
   assign rd_acc           = accept && (bus.data_sram_wen == DMEM_WEN_READ);
   assign wr_be            = wr_acc ? bus.data_sram_wen : 4'b0000;

   // Next state, latency counter and RAM read strobe.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      lat_idx_nxt = lat_idx;
      rd_en       = 1'b0;
      rd_idx      = lat_idx;
      case (state)
         DMEM_IDLE: begin
            if (rd_acc) begin
               if (READ_LAT == 1) begin
                  rd_en  = 1'b1;
                  rd_idx = req_idx;
               end else begin
                  lat_idx_nxt = req_idx;
                  cnt_nxt     = DMEM_CNT_BITS'(READ_LAT - 1);
                  state_nxt   = DMEM_BUSY;
               end
            end
         end
         DMEM_BUSY: begin
            cnt_nxt = cnt - 1'b1;
            if (cnt == DMEM_CNT_BITS'(1)) begin
               rd_en     = !rst;
               state_nxt = DMEM_IDLE;
            end
         end
         default: state_nxt = DMEM_IDLE;
      endcase
   end

   // Control state; rd_zero forces rdata to 0 from reset until the first read completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= DMEM_IDLE;
         cnt     <= '0;
         rd_zero <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (rd_en) begin
            rd_zero <= 1'b0;
         end
      end
   end

   // Latched read index is pure datapath and needs no reset.
   always_ff @(posedge clk) begin
      lat_idx <= lat_idx_nxt;
   end

   dmem_byte_ram #(
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .clk    (clk),
      .wr_be  (wr_be),
      .wr_idx (req_idx),
      .wr_dat (bus.data_sram_wdata),
      .rd_en  (rd_en),
      .rd_idx (rd_idx),
      .rd_dat (ram_q)
   );

   // RAM output register holds between reads, so rdata stays registered and stable.
   assign bus.data_sram_rdata = rd_zero ? 32'h0 : ram_q;

endmodule
